axi4lite_regbank_gen: RTL and testbench
=======================================

Name: axi4lite_regbank_gen

Overview:
Parametrised AXI4-Lite register-bank slave with N_RW read/write 32-bit control registers followed by N_RO read-only 32-bit status words, mapped at consecutive word addresses.
It is the generalised successor of the fixed-map generated register blocks.
It adds byte-strobe writes, SLVERR responses for unmapped or read-only writes, and per-register write/read strobe pulses.
It sits between the AXI4-Lite interconnect and the user logic of one subsystem.

Parameters:
N_RW, 4, number of RW registers (1..64), word indices 0..N_RW-1
N_RO, 4, number of RO words (0..64), word indices N_RW..N_RW+N_RO-1
ADDR_W, 8, byte address width; must satisfy 2^(ADDR_W-2) >= N_RW+N_RO
RW_RST, 32'h0, reset value applied to every RW register

Ports:
aclk  in  1  clock
areset_n  in  1  reset, asynchronous active-low
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_W  write byte address; bits [1:0] ignored
awprot  in  3  ignored
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data
wstrb  in  4  byte-lane enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response: 00 OKAY, 10 SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_W  read byte address
arprot  in  3  ignored
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  read response
rw_regs_o  out  32*N_RW  RW register contents; register k at [32k+31:32k]
rw_wstb_o  out  N_RW  one-cycle pulse in the cycle after RW register k is written
ro_regs_i  in  32*N_RO  RO status words; word j at [32j+31:32j]
ro_rstb_o  out  N_RO  one-cycle pulse in the cycle RO word j is sampled

Behaviour:
- Decided interface rule: one clock aclk; reset areset_n is asynchronous, active-low.
- Reset values (asserted asynchronously):
  - bvalid, rvalid, bresp, rresp, rdata, rw_wstb_o and ro_rstb_o are 0.
  - Every RW register takes RW_RST.
  - awready, wready and arready are 1 from the first edge after reset release.
  - Reset mid-transaction drops the pending transaction with no response.
- Address decode: index = addr[ADDR_W-1:2]. Index < N_RW selects RW; index < N_RW+N_RO selects RO; anything else is unmapped.
- Write FSM, one outstanding write:
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle. Each ready drops after its own handshake.
  - W_COMMIT: entered when both AW and W are held. Lasts 1 cycle. On a RW hit, bytes with wstrb[b]=1 are updated at the end of this cycle and rw_wstb_o[k] pulses in the next cycle.
    - wstrb=0000 gives OKAY with no data change, but the strobe still pulses.
    - A write to an RO or unmapped index leaves all state unchanged, gives SLVERR and no strobe.
  - W_RESP: bvalid=1 with bresp held stable until bready. On the handshake, bvalid drops and awready/wready return to 1 in the next cycle → W_IDLE.
  - Latency: AW+W handshake in cycle 0 → register updated at the end of cycle 1 → bvalid first high in cycle 2.
- Read FSM, one outstanding read:
  - R_IDLE: arready=1. On the AR handshake, latch the address → R_FETCH; arready=0.
  - R_FETCH: lasts 1 cycle. rdata is captured from the RW register, from ro_regs_i with ro_rstb_o[j]=1 in this cycle, or as 0 if unmapped with rresp=10.
  - R_RESP: rvalid=1; rdata and rresp are stable until rready → R_IDLE.
  - Latency: AR handshake in cycle 0 → rvalid high in cycle 2.
- Simultaneous read and write to the same RW register: the channels are independent. If R_FETCH coincides with W_COMMIT, the read returns the pre-write value.
- Backpressure: bready or rready held low stalls only its own channel indefinitely; the other channel keeps operating.
- N_RO=0: no RO words; ro_rstb_o and ro_regs_i are 1-bit dummies that are tied off or ignored.

Test Plan:
- Reset check: after release, rw_regs_o = all RW_RST, and awready = wready = arready = 1, bvalid = rvalid = 0.
- Full write: AW and W in the same cycle, addr 0x04, wdata 0xDEADBEEF, wstrb 1111. Reg1 = 0xDEADBEEF at cycle 2, rw_wstb_o[1] pulses once, bvalid in cycle 2 with bresp 00.
- Partial write: W first, AW three cycles later, addr 0x04, wdata 0x11223344, wstrb 0101. Reg1 = 0xDE22BE44, bresp 00.
- Error responses: write to index N_RW (the first RO word) gives bresp 10 and no register change. Read of index N_RW+N_RO gives rdata 0 and rresp 10.
- RO read: with ro_regs_i word 0 = 0xCAFE0001, read index N_RW. rdata = 0xCAFE0001, rresp 00, ro_rstb_o[0] pulses once, rvalid in cycle 2.
- Stall and reset: hold bready=0 for 10 cycles. bvalid stays 1 and the read channel still completes. Then assert areset_n mid-read: rvalid and bvalid drop immediately and registers return to RW_RST.

Source files
------------

// File: rtl/axi4lite_regbank_gen.sv
// AXI4-Lite register bank: N_RW read/write control words followed by N_RO read-only
// status words at consecutive word addresses, with byte strobes and per-register pulses.
module axi4lite_regbank_gen #(
  parameter int          N_RW   = 4,
  parameter int          N_RO   = 4,
  parameter int          ADDR_W = 8,
  parameter logic [31:0] RW_RST = 32'h0,
  localparam int         RO_W   = (N_RO > 0) ? N_RO : 1
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [ADDR_W-1:0]    awaddr,
  input  logic [2:0]           awprot,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [1:0]           bresp,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [ADDR_W-1:0]    araddr,
  input  logic [2:0]           arprot,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic [32*N_RW-1:0]   rw_regs_o,
  output logic [N_RW-1:0]      rw_wstb_o,
  input  logic [32*RO_W-1:0]   ro_regs_i,
  output logic [RO_W-1:0]      ro_rstb_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W:0] N_RW_L  = (IDX_W+1)'(N_RW);
  localparam logic [IDX_W:0] N_MAP_L = (IDX_W+1)'(N_RW + N_RO);

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rstate_t;

  wstate_t            wstate;
  rstate_t            rstate;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               aw_held;
  logic               w_held;
  logic [32*N_RW-1:0] rw_q;
  logic               aw_hs;
  logic               w_hs;
  logic               ar_hs;
  logic               w_rw_hit;
  logic [31:0]        rd_data;
  logic               rd_err;
  logic               unused;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign ar_hs     = arvalid && arready;
  assign w_rw_hit  = ({1'b0, w_idx} < N_RW_L);
  assign rw_regs_o = rw_q;
  assign unused    = ^{awprot, arprot, awaddr[1:0], araddr[1:0], ro_regs_i};

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wstate    <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      w_idx     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      rw_q      <= {N_RW{RW_RST}};
      rw_wstb_o <= '0;
    end else begin
      rw_wstb_o <= '0;
      unique case (wstate)
        W_IDLE: begin
          // AW and W are captured independently; each ready falls after its own handshake
          if (aw_hs) begin
            w_idx   <= awaddr[ADDR_W-1:2];
            aw_held <= 1'b1;
            awready <= 1'b0;
          end else if (!aw_held) begin
            awready <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_held  <= 1'b1;
            wready  <= 1'b0;
          end else if (!w_held) begin
            wready <= 1'b1;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) wstate <= W_COMMIT;
        end
        W_COMMIT: begin
          if (w_rw_hit) begin
            for (int unsigned k = 0; k < N_RW; k++) begin
              if (w_idx == IDX_W'(k)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                  if (wstrb_q[b]) rw_q[32*k+8*b +: 8] <= wdata_q[8*b +: 8];
                end
                rw_wstb_o[k] <= 1'b1;
              end
            end
          end
          bresp  <= w_rw_hit ? 2'b00 : 2'b10;
          bvalid <= 1'b1;
          wstate <= W_RESP;
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < N_RW; k++) begin
      if (r_idx == IDX_W'(k)) rd_data = rw_q[32*k +: 32];
    end
    for (int unsigned j = 0; j < N_RO; j++) begin
      if (r_idx == IDX_W'(N_RW + j)) rd_data = ro_regs_i[32*j +: 32];
    end
    rd_err = ({1'b0, r_idx} >= N_MAP_L);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rstate    <= R_IDLE;
      arready   <= 1'b0;
      r_idx     <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= 2'b00;
      ro_rstb_o <= '0;
    end else begin
      ro_rstb_o <= '0;
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx   <= araddr[ADDR_W-1:2];
            arready <= 1'b0;
            rstate  <= R_FETCH;
            // Strobe is registered here so it is high exactly in the fetch cycle
            for (int unsigned j = 0; j < N_RO; j++) begin
              if (araddr[ADDR_W-1:2] == IDX_W'(N_RW + j)) ro_rstb_o[j] <= 1'b1;
            end
          end else begin
            arready <= 1'b1;
          end
        end
        R_FETCH: begin
          rdata  <= rd_data;
          rresp  <= rd_err ? 2'b10 : 2'b00;
          rvalid <= 1'b1;
          rstate <= R_RESP;
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_regbank_gen.sv
// Scoreboard bench for axi4lite_regbank_gen: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_axi4lite_regbank_gen;
  localparam int          N_RW   = 4;
  localparam int          N_RO   = 4;
  localparam int          ADDR_W = 8;
  localparam logic [31:0] RST    = 32'h1234_5678;

  logic                 aclk;
  logic                 areset_n;
  logic                 awvalid, awready, wvalid, wready, bvalid, bready;
  logic                 arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0]    awaddr, araddr;
  logic [2:0]           awprot, arprot;
  logic [31:0]          wdata, rdata;
  logic [3:0]           wstrb;
  logic [1:0]           bresp, rresp;
  logic [32*N_RW-1:0]   rw_regs_o;
  logic [N_RW-1:0]      rw_wstb_o;
  logic [32*N_RO-1:0]   ro_regs_i;
  logic [N_RO-1:0]      ro_rstb_o;

  int checks = 0;
  int errors = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  int wstb_cnt[N_RW];
  int rstb_cnt[N_RO];
  int snap;

  axi4lite_regbank_gen #(.N_RW(N_RW), .N_RO(N_RO), .ADDR_W(ADDR_W), .RW_RST(RST)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rw_regs_o(rw_regs_o), .rw_wstb_o(rw_wstb_o),
    .ro_regs_i(ro_regs_i), .ro_rstb_o(ro_rstb_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (areset_n && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected actual=%0h required=none", bresp);
      end else chk("bresp", bresp, bq.pop_front());
    end
    if (areset_n && rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected actual=%0h required=none", {rresp, rdata});
      end else chk("rresp_rdata", {rresp, rdata}, rq.pop_front());
    end
    for (int k = 0; k < N_RW; k++) wstb_cnt[k] += int'(rw_wstb_o[k]);
    for (int j = 0; j < N_RO; j++) rstb_cnt[j] += int'(ro_rstb_o[j]);
  end

  task automatic send_aw(input logic [ADDR_W-1:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 30) begin @(posedge aclk); #1; n++; end
    chk("aw_ready_timeout", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 30) begin @(posedge aclk); #1; n++; end
    chk("w_ready_timeout", wready, 1'b1);
    @(posedge aclk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [ADDR_W-1:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 30) begin @(posedge aclk); #1; n++; end
    chk("ar_ready_timeout", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain(input string name, input bit with_b);
    int n = 0;
    while (((with_b && bq.size() != 0) || rq.size() != 0) && n < 100) begin
      @(posedge aclk); #1; n++;
    end
    chk(name, with_b ? bq.size() + rq.size() : rq.size(), 0);
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] exp_resp);
    bq.push_back(exp_resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
    drain("write_drain", 1'b1);
  endtask

  task automatic read(input logic [ADDR_W-1:0] a, input logic [1:0] exp_resp, input logic [31:0] exp_data);
    rq.push_back({exp_resp, exp_data});
    send_ar(a);
    drain("read_drain", 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int k = 0; k < N_RW; k++) wstb_cnt[k] = 0;
    for (int j = 0; j < N_RO; j++) rstb_cnt[j] = 0;
    areset_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101; wdata = '0; wstrb = '0;
    ro_regs_i = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'hCAFE_0001};

    repeat (2) @(posedge aclk);
    #1;
    chk("reset_regs", rw_regs_o, {4{RST}});
    chk("reset_valids", {bvalid, rvalid, rw_wstb_o, ro_rstb_o}, '0);
    chk("reset_data", {bresp, rresp, rdata}, '0);
    areset_n = 1'b1;
    @(posedge aclk); #1;
    chk("ready_after_reset", {awready, wready, arready}, 3'b111);
    chk("idle_valids", {bvalid, rvalid}, 2'b00);

    // Full write, same-cycle AW+W, with cycle-accurate latency checks
    snap = wstb_cnt[1];
    bq.push_back(2'b00);
    fork
      send_aw(8'h04);
      send_w(32'hDEAD_BEEF, 4'b1111);
    join
    chk("bvalid_cycle1", bvalid, 1'b0);
    chk("reg1_cycle1", rw_regs_o[63:32], RST);
    @(posedge aclk); #1;
    chk("reg1_cycle2", rw_regs_o[63:32], 32'hDEAD_BEEF);
    chk("wstb_cycle2", rw_wstb_o, 4'b0010);
    chk("bvalid_cycle2", bvalid, 1'b1);
    drain("full_drain", 1'b1);
    chk("wstb1_count", wstb_cnt[1] - snap, 1);

    // Partial write: W first, AW three cycles later
    bq.push_back(2'b00);
    fork
      send_w(32'h1122_3344, 4'b0101);
      begin repeat (3) @(posedge aclk); #1; send_aw(8'h04); end
    join
    drain("partial_drain", 1'b1);
    chk("reg1_partial", rw_regs_o[63:32], 32'hDE22_BE44);

    // Zero-strobe write: OKAY, no change, strobe still pulses
    snap = wstb_cnt[0];
    write(8'h00, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    chk("reg0_zero_strb", rw_regs_o[31:0], RST);
    chk("wstb0_zero_strb", wstb_cnt[0] - snap, 1);

    // Writes to RO and unmapped indices
    snap = wstb_cnt[0] + wstb_cnt[1] + wstb_cnt[2] + wstb_cnt[3];
    write(8'h10, 32'h0, 4'b1111, 2'b10);
    write(8'h20, 32'h5555_AAAA, 4'b1111, 2'b10);
    chk("regs_after_err", rw_regs_o, {RST, RST, 32'hDE22_BE44, RST});
    chk("wstb_after_err", wstb_cnt[0] + wstb_cnt[1] + wstb_cnt[2] + wstb_cnt[3] - snap, 0);

    // Reads: unmapped, RO with latency, RW
    read(8'h20, 2'b10, 32'h0);
    read(8'hFC, 2'b10, 32'h0);
    snap = rstb_cnt[0];
    rq.push_back({2'b00, 32'hCAFE_0001});
    send_ar(8'h10);
    chk("ro_rstb_fetch", ro_rstb_o, 4'b0001);
    chk("rvalid_cycle1", rvalid, 1'b0);
    @(posedge aclk); #1;
    chk("rvalid_cycle2", rvalid, 1'b1);
    chk("ro_rstb_after", ro_rstb_o, 4'b0000);
    drain("ro_drain", 1'b0);
    chk("ro_rstb0_count", rstb_cnt[0] - snap, 1);
    read(8'h1C, 2'b00, 32'h4444_0004);
    read(8'h04, 2'b00, 32'hDE22_BE44);

    // Read coinciding with commit returns the pre-write value
    bq.push_back(2'b00);
    rq.push_back({2'b00, RST});
    fork
      send_aw(8'h08);
      send_w(32'hAAAA_5555, 4'b1111);
      send_ar(8'h08);
    join
    drain("overlap_drain", 1'b1);
    chk("reg2_overlap", rw_regs_o[95:64], 32'hAAAA_5555);
    read(8'h08, 2'b00, 32'hAAAA_5555);

    // B backpressure: read channel still works
    bready = 1'b0;
    bq.push_back(2'b00);
    fork
      send_aw(8'h0C);
      send_w(32'h0BAD_F00D, 4'b1111);
    join
    @(posedge aclk); #1;
    for (int i = 0; i < 10; i++) begin
      chk("bvalid_stall", bvalid, 1'b1);
      @(posedge aclk); #1;
    end
    read(8'h0C, 2'b00, 32'h0BAD_F00D);
    chk("bvalid_still_held", {bvalid, bresp}, 3'b100);

    // Reset in the middle of a read with a pending write response
    rready = 1'b0;
    send_ar(8'h04);
    @(posedge aclk); #1;
    chk("rvalid_before_reset", rvalid, 1'b1);
    areset_n = 1'b0;
    #1;
    chk("valids_in_reset", {bvalid, rvalid}, 2'b00);
    chk("regs_in_reset", rw_regs_o, {4{RST}});
    bq.delete();
    rq.delete();
    bready = 1'b1; rready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset_n = 1'b1;
    @(posedge aclk); #1;
    chk("ready_after_reset2", {awready, wready, arready}, 3'b111);
    read(8'h04, 2'b00, RST);
    write(8'h00, 32'h0000_00A5, 4'b0001, 2'b00);
    chk("reg0_after_reset", rw_regs_o[31:0], 32'h1234_56A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
